// File: rtl/mf_capture_sequencer_pkg.sv
// Shared types and constants for the capture sequencer: FSM states,
// configuration register addresses and CTRL bit positions.
package mf_capture_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ARMED   = 3'd1,
    ST_HOLDOFF = 3'd2,
    ST_CAPTURE = 3'd3,
    ST_DONE    = 3'd4
  } state_e;

  localparam logic [1:0] ADDR_SEL     = 2'd0;
  localparam logic [1:0] ADDR_HOLDOFF = 2'd1;
  localparam logic [1:0] ADDR_LENGTH  = 2'd2;
  localparam logic [1:0] ADDR_CTRL    = 2'd3;

  localparam int CTRL_AUTO_REARM = 0;
  localparam int CTRL_SW_TRIG    = 1;

endpackage

// File: rtl/mf_capture_sequencer_if.sv
// Stream bundle between the ADC/matched-filter sources and the capture buffers.
interface mf_capture_sequencer_if #(
  parameter int NSRC = 4,
  parameter int NBUF = 4,
  parameter int DW   = 128
);
  logic [NSRC*DW-1:0] src_tdata_i;
  logic [NSRC-1:0]    src_tvalid_i;
  logic [NBUF*DW-1:0] buf_tdata_o;
  logic [NBUF-1:0]    buf_tvalid_o;
  logic [NBUF-1:0]    buf_tready_i;

  modport slave (
    input  src_tdata_i, src_tvalid_i, buf_tready_i,
    output buf_tdata_o, buf_tvalid_o
  );

  modport master (
    output src_tdata_i, src_tvalid_i, buf_tready_i,
    input  buf_tdata_o, buf_tvalid_o
  );
endinterface

// File: rtl/mf_capture_sequencer_router.sv
// One buffer lane: registered NSRC:1 source mux with the valid gated by the
// capture window. Out-of-range selects produce zero data and no valid.
module mf_stream_router #(
  parameter int NSRC = 4,
  parameter int DW   = 128,
  parameter int SELW = 2
) (
  input  logic               aclk,
  input  logic               aclk_rst_i,
  input  logic [SELW-1:0]    sel_i,
  input  logic               window_i,
  input  logic [NSRC*DW-1:0] src_tdata_i,
  input  logic [NSRC-1:0]    src_tvalid_i,
  output logic [DW-1:0]      tdata_o,
  output logic               tvalid_o
);

  logic [DW-1:0] tdata_d, tdata_q;
  logic          tvalid_d, tvalid_q;

  always_comb begin
    tdata_d  = '0;
    tvalid_d = 1'b0;
    for (int k = 0; k < NSRC; k++) begin
      if (int'(sel_i) == k) begin
        tdata_d  = src_tdata_i[k*DW +: DW];
        tvalid_d = window_i & src_tvalid_i[k];
      end
    end
  end

  always_ff @(posedge aclk) begin
    if (aclk_rst_i) begin
      tdata_q  <= '0;
      tvalid_q <= 1'b0;
    end else begin
      tdata_q  <= tdata_d;
      tvalid_q <= tvalid_d;
    end
  end

  assign tdata_o  = tdata_q;
  assign tvalid_o = tvalid_q;

endmodule

// File: rtl/mf_capture_sequencer.sv
// Capture sequencer: register file, arm/trigger/hold-off/capture FSM and
// per-buffer stream routing with a cycle-exact valid window.
module mf_capture_sequencer
  import mf_capture_pkg::*;
#(
  parameter int NSRC = 4,
  parameter int NBUF = 4,
  parameter int DW   = 128,
  parameter int SELW = 2,
  parameter int CW   = 16
) (
  input  logic        aclk,
  input  logic        aclk_rst_i,
  input  logic        cfg_wr_i,
  input  logic [1:0]  cfg_addr_i,
  input  logic [31:0] cfg_dat_i,
  input  logic        arm_i,
  input  logic        abort_i,
  input  logic        capture_i,
  mf_capture_sequencer_if.slave strm,
  output logic [2:0]  state_o,
  output logic        done_o,
  output logic        overflow_o,
  output logic [7:0]  trig_missed_o
);

  localparam int SW = NBUF*SELW;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [SW-1:0]   sel_q, sel_d, sel_sh_q;
  logic [CW-1:0]   hold_q, hold_d, hold_sh_q;
  logic [CW-1:0]   len_q, len_d, len_sh_q;
  logic            auto_q, auto_d;
  logic            cap_prev_q;
  logic            done_q, ovf_q, ovf_d;
  logic [7:0]      miss_q, miss_d;
  logic            sw_trig, trig, arm_ok, enter_armed, win_d;
  logic [NBUF-1:0] buf_vld;
  logic            unused_cfg;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  assign unused_cfg = ^cfg_dat_i;

  always_comb begin
    sel_d   = sel_q;
    hold_d  = hold_q;
    len_d   = len_q;
    auto_d  = auto_q;
    sw_trig = 1'b0;
    if (cfg_wr_i) begin
      case (cfg_addr_i)
        ADDR_SEL:     sel_d  = cfg_dat_i[SW-1:0];
        ADDR_HOLDOFF: hold_d = cfg_dat_i[CW-1:0];
        ADDR_LENGTH:  len_d  = cfg_dat_i[CW-1:0];
        default: begin
          auto_d  = cfg_dat_i[CTRL_AUTO_REARM];
          sw_trig = cfg_dat_i[CTRL_SW_TRIG];
        end
      endcase
    end
  end

  // A simultaneous pin edge and software trigger collapse into one event.
  assign trig = (capture_i & ~cap_prev_q) | sw_trig;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    arm_ok  = 1'b0;
    if (abort_i) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: if (arm_i) begin
          state_d = ST_ARMED;
          arm_ok  = 1'b1;
        end
        ST_ARMED: if (trig) begin
          state_d = ST_HOLDOFF;
          cnt_d   = hold_sh_q;
        end
        ST_HOLDOFF: begin
          if (cnt_q == '0) begin
            if (len_sh_q == '0) begin
              state_d = ST_DONE;
            end else begin
              state_d = ST_CAPTURE;
              cnt_d   = len_sh_q;
            end
          end else begin
            cnt_d = cnt_q - CW'(1);
          end
        end
        ST_CAPTURE: begin
          if (cnt_q <= CW'(1)) state_d = ST_DONE;
          else                 cnt_d   = cnt_q - CW'(1);
        end
        ST_DONE: begin
          if (arm_i) begin
            state_d = ST_ARMED;
            arm_ok  = 1'b1;
          end else if (auto_q) begin
            state_d = ST_ARMED;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  assign enter_armed = (state_d == ST_ARMED) && (state_q != ST_ARMED);
  assign win_d       = (state_d == ST_CAPTURE);

  always_comb begin
    ovf_d = arm_ok ? 1'b0 : (ovf_q | (|(buf_vld & ~strm.buf_tready_i)));
    if (arm_i)
      miss_d = 8'd0;
    else if (trig && (state_q inside {ST_HOLDOFF, ST_CAPTURE, ST_DONE}))
      miss_d = sat_inc8(miss_q);
    else
      miss_d = miss_q;
  end

  always_ff @(posedge aclk) begin
    if (aclk_rst_i) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      sel_q      <= '0;
      hold_q     <= '0;
      len_q      <= CW'(1);
      auto_q     <= 1'b0;
      sel_sh_q   <= '0;
      hold_sh_q  <= '0;
      len_sh_q   <= CW'(1);
      cap_prev_q <= 1'b0;
      done_q     <= 1'b0;
      ovf_q      <= 1'b0;
      miss_q     <= 8'd0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      sel_q      <= sel_d;
      hold_q     <= hold_d;
      len_q      <= len_d;
      auto_q     <= auto_d;
      cap_prev_q <= capture_i;
      done_q     <= (state_d == ST_DONE);
      ovf_q      <= ovf_d;
      miss_q     <= miss_d;
      // Shadows take this cycle's writes so a write coincident with arming counts.
      if (enter_armed) begin
        sel_sh_q  <= sel_d;
        hold_sh_q <= hold_d;
        len_sh_q  <= len_d;
      end
    end
  end

  for (genvar b = 0; b < NBUF; b++) begin : g_buf
    mf_stream_router #(
      .NSRC(NSRC),
      .DW  (DW),
      .SELW(SELW)
    ) u_router (
      .aclk        (aclk),
      .aclk_rst_i  (aclk_rst_i),
      .sel_i       (sel_sh_q[b*SELW +: SELW]),
      .window_i    (win_d),
      .src_tdata_i (strm.src_tdata_i),
      .src_tvalid_i(strm.src_tvalid_i),
      .tdata_o     (strm.buf_tdata_o[b*DW +: DW]),
      .tvalid_o    (buf_vld[b])
    );
  end

  assign strm.buf_tvalid_o = buf_vld;
  assign state_o           = state_q;
  assign done_o            = done_q;
  assign overflow_o        = ovf_q;
  assign trig_missed_o     = miss_q;

endmodule

// File: tb/tb_mf_capture_sequencer.sv
// Directed scenarios with random source data, checked every cycle against a
// timestamp-based model of the capture schedule.
module tb_mf_capture_sequencer;
  localparam int NSRC = 4, NBUF = 4, DW = 128, SELW = 2, CW = 16;

  logic        aclk = 1'b0;
  logic        rst = 1'b1;
  logic        cfg_wr = 1'b0;
  logic [1:0]  cfg_addr = 2'd0;
  logic [31:0] cfg_dat = 32'd0;
  logic        arm = 1'b0, abort = 1'b0, capture = 1'b0;
  logic [2:0]  state;
  logic        done, ovf;
  logic [7:0]  missed;

  always #5 aclk = ~aclk;

  mf_capture_sequencer_if #(.NSRC(NSRC), .NBUF(NBUF), .DW(DW)) strm ();

  mf_capture_sequencer #(
    .NSRC(NSRC), .NBUF(NBUF), .DW(DW), .SELW(SELW), .CW(CW)
  ) dut (
    .aclk         (aclk),
    .aclk_rst_i   (rst),
    .cfg_wr_i     (cfg_wr),
    .cfg_addr_i   (cfg_addr),
    .cfg_dat_i    (cfg_dat),
    .arm_i        (arm),
    .abort_i      (abort),
    .capture_i    (capture),
    .strm         (strm),
    .state_o      (state),
    .done_o       (done),
    .overflow_o   (ovf),
    .trig_missed_o(missed)
  );

  int n_chk = 0, n_fail = 0, beats = 0, cyc = 0;
  bit vrand = 1'b0;

  // Reference model: a capture is a set of absolute cycle numbers fixed at trigger time.
  bit m_armed, m_run, m_done, m_prev, r_auto;
  int t_first, t_last, t_done;
  logic [7:0] r_sel, sh_sel;
  int r_h, r_l, sh_h, sh_l;
  logic [NBUF-1:0]    e_vld;
  logic [NBUF*DW-1:0] e_data;
  bit e_done, e_ovf;
  int e_miss, e_state;

  task automatic model_step();
    bit trig, arm_ok, enter, old_auto, ovf_set, cnt_miss;
    int s;
    logic [NBUF-1:0]    nv;
    logic [NBUF*DW-1:0] nd;
    if (rst) begin
      m_armed = 0; m_run = 0; m_done = 0; r_auto = 0;
      r_sel = 8'd0; sh_sel = 8'd0; r_h = 0; sh_h = 0; r_l = 1; sh_l = 1;
      e_vld = '0; e_data = '0; e_done = 0; e_ovf = 0; e_miss = 0;
    end else begin
      trig    = (capture && !m_prev) || (cfg_wr && cfg_addr == 2'd3 && cfg_dat[1]);
      ovf_set = |(e_vld & ~strm.buf_tready_i);
      for (int b = 0; b < NBUF; b++) begin
        s = int'(sh_sel[b*SELW +: SELW]);
        nd[b*DW +: DW] = (s < NSRC) ? strm.src_tdata_i[s*DW +: DW] : '0;
        nv[b] = (s < NSRC) && strm.src_tvalid_i[s];
      end
      old_auto = r_auto;
      if (cfg_wr) begin
        case (cfg_addr)
          2'd0: r_sel = cfg_dat[7:0];
          2'd1: r_h = int'(cfg_dat[15:0]);
          2'd2: r_l = int'(cfg_dat[15:0]);
          default: r_auto = cfg_dat[0];
        endcase
      end
      cnt_miss = trig && (m_run || m_done);
      arm_ok = 0; enter = 0;
      if (abort) begin
        m_armed = 0; m_run = 0; m_done = 0;
      end else if (m_armed) begin
        if (trig) begin
          m_armed = 0; m_run = 1;
          t_first = cyc + sh_h + 2;
          t_last  = cyc + sh_h + sh_l + 1;
          t_done  = t_last + 1;
        end
      end else if (m_run) begin
        if (cyc + 1 == t_done) begin m_run = 0; m_done = 1; end
      end else if (m_done) begin
        if (arm) begin arm_ok = 1; enter = 1; end
        else if (old_auto) enter = 1;
      end else if (arm) begin
        arm_ok = 1; enter = 1;
      end
      if (enter) begin
        m_armed = 1; m_done = 0; sh_sel = r_sel; sh_h = r_h; sh_l = r_l;
      end
      if (arm) e_miss = 0;
      else if (cnt_miss && e_miss < 255) e_miss++;
      e_ovf  = arm_ok ? 1'b0 : (e_ovf | ovf_set);
      e_vld  = (m_run && cyc + 1 >= t_first && cyc + 1 <= t_last) ? nv : '0;
      e_data = nd;
      e_done = m_done;
    end
    m_prev = rst ? 1'b0 : capture;
    cyc++;
    e_state = m_armed ? 1 : m_done ? 4 : m_run ? ((cyc < t_first) ? 2 : 3) : 0;
  endtask

  task automatic chk_int(input string tag, input int got, input int exp);
    n_chk++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s cyc=%0d observed=%0d expected=%0d", tag, cyc, got, exp);
    end
  endtask

  task automatic check_outputs();
    n_chk++;
    assert (strm.buf_tvalid_o === e_vld) else begin
      n_fail++;
      $error("FAIL tvalid cyc=%0d observed=%b expected=%b", cyc, strm.buf_tvalid_o, e_vld);
    end
    n_chk++;
    assert (strm.buf_tdata_o === e_data) else begin
      n_fail++;
      $error("FAIL tdata cyc=%0d observed=%h expected=%h", cyc, strm.buf_tdata_o, e_data);
    end
    chk_int("done", int'(done), int'(e_done));
    chk_int("overflow", int'(ovf), int'(e_ovf));
    chk_int("trig_missed", int'(missed), e_miss);
    chk_int("state", int'(state), e_state);
    if (strm.buf_tvalid_o[0] === 1'b1) beats++;
  endtask

  task automatic drive_src();
    for (int k = 0; k < NSRC*DW/32; k++) strm.src_tdata_i[k*32 +: 32] = $urandom();
    strm.src_tvalid_i = vrand ? NSRC'($urandom_range(0, 15)) : '1;
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge aclk);
      model_step();
      #1;
      cfg_wr = 1'b0; arm = 1'b0; abort = 1'b0;
      check_outputs();
      drive_src();
    end
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    cfg_wr = 1'b1; cfg_addr = a; cfg_dat = d;
    tick(1);
  endtask

  task automatic edge_trig();
    capture = 1'b1; tick(1); capture = 1'b0;
  endtask

  initial begin
    strm.buf_tready_i = '1;
    drive_src();
    tick(2);
    rst = 1'b0;
    tick(1);

    // Full routing, H=3 L=8, pin trigger
    wr(2'd0, 32'hE4); wr(2'd1, 32'd3); wr(2'd2, 32'd8);
    arm = 1'b1; tick(1); tick(2);
    beats = 0;
    edge_trig();
    tick(13);
    chk_int("beats_h3_l8", beats, 8);
    chk_int("done_after_l8", int'(done), 1);

    // H=0 L=1 via software trigger, then LENGTH=0
    wr(2'd1, 32'd0); wr(2'd2, 32'd1);
    arm = 1'b1; tick(2);
    beats = 0;
    wr(2'd3, 32'd2);
    tick(5);
    chk_int("beats_h0_l1", beats, 1);
    wr(2'd2, 32'd0);
    arm = 1'b1; tick(2);
    beats = 0;
    wr(2'd3, 32'd2);
    tick(4);
    chk_int("beats_l0", beats, 0);
    chk_int("state_l0", int'(state), 4);

    // Retrigger and LENGTH write during capture
    wr(2'd1, 32'd3); wr(2'd2, 32'd8);
    arm = 1'b1; tick(2);
    beats = 0;
    edge_trig();
    tick(6);
    edge_trig();
    wr(2'd2, 32'd20);
    tick(10);
    chk_int("beats_retrig", beats, 8);
    chk_int("missed_retrig", int'(missed), 1);
    arm = 1'b1; tick(2);
    beats = 0;
    wr(2'd3, 32'd2);
    tick(26);
    chk_int("beats_l20", beats, 20);

    // Auto-rearm with an overflow in the first window
    wr(2'd2, 32'd8);
    arm = 1'b1; tick(1);
    wr(2'd3, 32'd1);
    beats = 0;
    for (int i = 0; i < 3; i++) begin
      edge_trig();
      if (i == 0) begin
        tick(6); strm.buf_tready_i = 4'b1011; tick(2); strm.buf_tready_i = '1; tick(21);
      end else begin
        tick(29);
      end
    end
    chk_int("beats_auto", beats, 24);
    chk_int("ovf_sticky", int'(ovf), 1);

    // Abort together with arm during capture
    wr(2'd3, 32'd0);
    edge_trig();
    tick(8);
    abort = 1'b1; arm = 1'b1; tick(1);
    chk_int("state_abort", int'(state), 0);
    chk_int("tvalid_abort", int'(strm.buf_tvalid_o), 0);
    tick(3);

    // Reset during hold-off
    arm = 1'b1; tick(1);
    edge_trig();
    tick(2);
    rst = 1'b1; tick(1);
    chk_int("state_rst", int'(state), 0);
    chk_int("tdata_rst", int'(strm.buf_tdata_o == '0), 1);
    rst = 1'b0; tick(2);

    // Random source valids mirrored inside the window
    vrand = 1'b1;
    wr(2'd0, 32'hE4); wr(2'd1, 32'd3); wr(2'd2, 32'd8);
    arm = 1'b1; tick(2);
    edge_trig();
    tick(14);
    chk_int("state_vrand", int'(state), 4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/mf_capture_sequencer.md
Name: mf_capture_sequencer

Overview:
Capture sequencer and stream router for the matched-filter test design. It selects which of the raw ADC or matched-filter output streams feeds each capture buffer, and arms on command. On a trigger edge it waits a programmable hold-off, then asserts buffer tvalid for exactly a programmed number of beats. It sits between the ADC/matched_filter outputs and the buf0..buf3 AXI4-Stream ports, and a small register write port configures it.

Parameters:
NSRC, 4, number of source streams (0=adc0, 1=adc1, 2=match0, 3=match1)
NBUF, 4, number of buffer outputs
DW, 128, stream data width
SELW, 2, source-select width per buffer (clog2(NSRC))
CW, 16, hold-off and length counter width

Ports:
aclk  in  1  clock for all logic
aclk_rst_i  in  1  synchronous, active-high reset
cfg_wr_i  in  1  register write strobe
cfg_addr_i  in  2  0=SEL, 1=HOLDOFF, 2=LENGTH, 3=CTRL
cfg_dat_i  in  32  write data
arm_i  in  1  arm pulse
abort_i  in  1  abort pulse
capture_i  in  1  hardware trigger level
src_tdata_i  in  NSRC*DW  source data, source k at [k*DW +: DW]
src_tvalid_i  in  NSRC  source valids
buf_tdata_o  out  NBUF*DW  routed data
buf_tvalid_o  out  NBUF  gated valid
buf_tready_i  in  NBUF  buffer ready (used only for overflow detection)
state_o  out  3  FSM state encoding
done_o  out  1  high while in DONE
overflow_o  out  1  sticky: beat dropped by a buffer
trig_missed_o  out  8  saturating count of ignored triggers

Behaviour:
- Reset: state IDLE; all outputs 0; registers SEL=0, HOLDOFF=0, LENGTH=1, CTRL=0.
- Registers are writable in any state. SEL bits [b*SELW +: SELW] pick the source for buffer b; HOLDOFF[CW-1:0]; LENGTH[CW-1:0]; CTRL bit0=auto_rearm, bit1=sw_trig (self-clearing pulse, never stored).
- Shadow copies of SEL, HOLDOFF and LENGTH latch on the cycle the FSM enters ARMED. Writes made after that take effect on the next arm.
- Trigger event: capture_i high this cycle and low the previous cycle (internal prev register, reset 0), OR a sw_trig write. Two triggers in the same cycle count as one.
- States: IDLE(0), ARMED(1), HOLDOFF(2), CAPTURE(3), DONE(4).
  - IDLE/DONE -> ARMED on arm_i.
  - ARMED -> HOLDOFF on trigger; counter loads HOLDOFF.
  - HOLDOFF: if counter==0 -> CAPTURE with beat counter = LENGTH, else decrement.
  - CAPTURE: decrement each cycle; at beat count 1 -> DONE.
  - DONE: if auto_rearm -> ARMED next cycle (re-latch shadows), else stay.
  - abort_i in any state -> IDLE next cycle. abort wins over arm_i and trigger in the same cycle.
- LENGTH=0: HOLDOFF -> DONE directly, no beats emitted.
- Timing: trigger at cycle T gives the first buf_tvalid_o at T+H+2 and the last at T+H+L+1 (H=HOLDOFF, L=LENGTH). Exactly L beats, contiguous.
- buf_tdata_o[b] is registered every cycle (1-cycle latency) from the selected source, regardless of state.
- buf_tvalid_o[b] (registered) = capture-window & src_tvalid_i[sel_b] from the previous cycle. The beat counter counts cycles, not valid beats.
- SEL value >= NSRC: that buffer's tvalid stays 0 and tdata is 0.
- overflow_o sets when buf_tvalid_o[b] & ~buf_tready_i[b]. It clears on entering ARMED from IDLE/DONE via arm_i; auto-rearm does not clear it.
- trig_missed_o increments on triggers seen in HOLDOFF, CAPTURE or DONE, saturates at 255, and clears on arm_i.
- After abort, buf_tvalid_o is 0 from cycle A+1 (abort at A); a partial capture is not completed.

Decomposition:
- Package mf_capture_pkg: state enum, register address constants, CTRL bit indices.
- Sub-module mf_stream_router: registered NSRC:1 mux plus valid gating per buffer, instantiated NBUF times via generate.
- FSM, counters and register file stay in the top module.

Test Plan:
- SEL=0xE4 (buf0<-adc0, buf1<-adc1, buf2<-m0, buf3<-m1), H=3, L=8, arm, capture_i edge at T -> all buf_tvalid_o high for cycles T+5..T+12, data = source delayed by 1, done_o at T+13.
- H=0, L=1, sw_trig write -> exactly one beat at T+2; LENGTH=0 -> DONE with no beats.
- Second capture_i edge during CAPTURE and a write of LENGTH=20 mid-capture -> capture still 8 beats; trig_missed_o=1; next arm uses L=20.
- auto_rearm=1, three edges spaced 30 cycles apart -> three 8-beat windows; overflow_o forced by buf_tready_i[2]=0 mid-window stays set across rearms.
- abort_i asserted 4 cycles into CAPTURE together with arm_i -> IDLE, buf_tvalid_o=0 from next cycle; aclk_rst_i mid-HOLDOFF -> all outputs 0 next cycle.
- SEL for buf3 set to 3 with src_tvalid_i[3] toggling -> buf_tvalid_o[3] mirrors it delayed 1 cycle within the window; beat count unaffected.
